// File: rtl/lvds_input_axi_write.sv
// AXI4-Lite write slave for the LVDS input CR/SR/DSIZE registers; 3-cycle minimum transaction, one outstanding write, B held until BREADY.
// Define LVDS_INPUT_WSTRB_EN to honour WSTRB byte lanes; otherwise every write updates the full register.
module lvds_input_axi_write #(
  parameter logic [31:0] DSIZE_RESET = 32'd0
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  output logic        cr_test,
  output logic        cr_rt,
  output logic [31:0] dsize,
  output logic        sr_pc_clr
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RESP} state_t;

  localparam logic [7:0] ADDR_CR    = 8'h00;
  localparam logic [7:0] ADDR_SR    = 8'h04;
  localparam logic [7:0] ADDR_DSIZE = 8'h08;

  state_t      state_q;
  logic        awready_q, wready_q, bvalid_q;
  logic        cr_test_q, cr_test_d;
  logic        cr_rt_q, cr_rt_d;
  logic [31:0] dsize_q, dsize_d;
  logic        sr_pc_clr_q, sr_pc_clr_d;
  logic [3:0]  lane_en;
  logic        unused_ok;

`ifdef LVDS_INPUT_WSTRB_EN
  assign lane_en = WSTRB;
`else
  assign lane_en = 4'hF;
`endif

  assign unused_ok = ^{AWADDR[31:8], WSTRB};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // AW and W are taken together or not at all.
          if (AWVALID && WVALID) begin
            state_q   <= S_WRITE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        S_WRITE: begin
          state_q   <= S_RESP;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b1;
        end
        S_RESP: begin
          if (BREADY) begin
            state_q  <= S_IDLE;
            bvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cr_test_d   = cr_test_q;
    cr_rt_d     = cr_rt_q;
    dsize_d     = dsize_q;
    sr_pc_clr_d = 1'b0;
    if (state_q == S_WRITE) begin
      case (AWADDR[7:0])
        ADDR_CR: begin
          if (lane_en[0]) begin
            cr_test_d = WDATA[0];
            cr_rt_d   = WDATA[1];
          end
        end
        ADDR_SR: sr_pc_clr_d = lane_en[0] & WDATA[0];
        ADDR_DSIZE: begin
          for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) dsize_d[8*k +: 8] = WDATA[8*k +: 8];
          end
        end
        default: ;
      endcase
    end
    // Capture size is word-granular.
    dsize_d[1:0] = 2'b00;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cr_test_q   <= 1'b0;
      cr_rt_q     <= 1'b0;
      dsize_q     <= {DSIZE_RESET[31:2], 2'b00};
      sr_pc_clr_q <= 1'b0;
    end else begin
      cr_test_q   <= cr_test_d;
      cr_rt_q     <= cr_rt_d;
      dsize_q     <= dsize_d;
      sr_pc_clr_q <= sr_pc_clr_d;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = 2'b00;
  assign cr_test   = cr_test_q;
  assign cr_rt     = cr_rt_q;
  assign dsize     = dsize_q;
  assign sr_pc_clr = sr_pc_clr_q;

endmodule

// File: tb/tb_lvds_input_axi_write.sv
// Directed bench for lvds_input_axi_write; build with LVDS_INPUT_WSTRB_EN to cover the byte-strobe variant.
module tb_lvds_input_axi_write;

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        cr_test;
  logic        cr_rt;
  logic [31:0] dsize;
  logic        sr_pc_clr;

  int checks = 0;
  int errors = 0;

  lvds_input_axi_write dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .AWADDR    (AWADDR),
    .AWVALID   (AWVALID),
    .AWREADY   (AWREADY),
    .WDATA     (WDATA),
    .WSTRB     (WSTRB),
    .WVALID    (WVALID),
    .WREADY    (WREADY),
    .BRESP     (BRESP),
    .BVALID    (BVALID),
    .BREADY    (BREADY),
    .cr_test   (cr_test),
    .cr_rt     (cr_rt),
    .dsize     (dsize),
    .sr_pc_clr (sr_pc_clr)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle N+2 (B phase) with valids dropped.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    AWADDR  = addr;
    WDATA   = data;
    WSTRB   = strb;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    @(negedge ACLK);
    chk1("awready_n1", AWREADY, 1'b1);
    chk1("wready_n1", WREADY, 1'b1);
    chk1("bvalid_n1", BVALID, 1'b0);
    chk1("pc_clr_n1", sr_pc_clr, 1'b0);
    @(negedge ACLK);
    chk1("bvalid_n2", BVALID, 1'b1);
    chk("bresp_n2", {30'd0, BRESP}, 32'd0);
    chk1("awready_n2", AWREADY, 1'b0);
    AWVALID = 1'b0;
    WVALID  = 1'b0;
  endtask

  initial begin
    ARESETN = 1'b0;
    AWADDR  = 32'd0;
    AWVALID = 1'b0;
    WDATA   = 32'd0;
    WSTRB   = 4'hF;
    WVALID  = 1'b0;
    BREADY  = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);

    // Reset state
    chk1("rst_awready", AWREADY, 1'b0);
    chk1("rst_wready", WREADY, 1'b0);
    chk1("rst_bvalid", BVALID, 1'b0);
    chk("rst_bresp", {30'd0, BRESP}, 32'd0);
    chk1("rst_cr_test", cr_test, 1'b0);
    chk1("rst_cr_rt", cr_rt, 1'b0);
    chk("rst_dsize", dsize, 32'd0);
    chk1("rst_pc_clr", sr_pc_clr, 1'b0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // CR <- 3
    axi_write(32'h00, 32'h0000_0003, 4'hF);
    chk1("cr3_test", cr_test, 1'b1);
    chk1("cr3_rt", cr_rt, 1'b1);
    @(negedge ACLK);
    chk1("cr3_bvalid_drop", BVALID, 1'b0);

    // DSIZE <- 0x1003
    axi_write(32'h08, 32'h0000_1003, 4'hF);
    chk("dsize_1000", dsize, 32'h0000_1000);
    @(negedge ACLK);

    // Unmapped offset
    axi_write(32'h20, 32'hFFFF_FFFF, 4'hF);
    chk1("unmap_cr_test", cr_test, 1'b1);
    chk1("unmap_cr_rt", cr_rt, 1'b1);
    chk("unmap_dsize", dsize, 32'h0000_1000);
    chk1("unmap_pc_clr", sr_pc_clr, 1'b0);
    @(negedge ACLK);

    // SR W1C pulse
    axi_write(32'h04, 32'h0000_0001, 4'hF);
    chk1("sr1_pulse", sr_pc_clr, 1'b1);
    @(negedge ACLK);
    chk1("sr1_pulse_end", sr_pc_clr, 1'b0);
    chk1("sr1_cr_test", cr_test, 1'b1);

    axi_write(32'h04, 32'h0000_0000, 4'hF);
    chk1("sr0_no_pulse", sr_pc_clr, 1'b0);
    @(negedge ACLK);
    chk1("sr0_no_pulse_n3", sr_pc_clr, 1'b0);

    // CR <- 2
    axi_write(32'h00, 32'h0000_0002, 4'hF);
    chk1("cr2_test", cr_test, 1'b0);
    chk1("cr2_rt", cr_rt, 1'b1);
    @(negedge ACLK);

    // AW alone, then W; B held off with a second pair pending
    BREADY  = 1'b0;
    AWADDR  = 32'h08;
    WDATA   = 32'h2000_0007;
    WSTRB   = 4'hF;
    AWVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk1("aw_only_awready", AWREADY, 1'b0);
      chk1("aw_only_wready", WREADY, 1'b0);
    end
    WVALID = 1'b1;
    @(negedge ACLK);
    chk1("aw_w_awready", AWREADY, 1'b1);
    chk1("aw_w_wready", WREADY, 1'b1);
    @(negedge ACLK);
    chk1("hold_bvalid_first", BVALID, 1'b1);
    chk("hold_dsize", dsize, 32'h2000_0004);
    AWADDR = 32'h00;
    WDATA  = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk1("hold_bvalid", BVALID, 1'b1);
      chk1("hold_awready", AWREADY, 1'b0);
      chk1("hold_wready", WREADY, 1'b0);
    end
    chk1("hold_cr_rt", cr_rt, 1'b1);
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    BREADY  = 1'b1;
    @(negedge ACLK);
    chk1("hold_release", BVALID, 1'b0);
    chk1("hold_cr_rt_after", cr_rt, 1'b1);

    // Asynchronous reset while in S_RESP
    BREADY = 1'b0;
    axi_write(32'h00, 32'h0000_0003, 4'hF);
    chk1("pre_rst_cr_test", cr_test, 1'b1);
    #2 ARESETN = 1'b0;
    #1;
    chk1("arst_bvalid", BVALID, 1'b0);
    chk1("arst_cr_test", cr_test, 1'b0);
    chk1("arst_cr_rt", cr_rt, 1'b0);
    chk("arst_dsize", dsize, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    BREADY  = 1'b1;
    @(negedge ACLK);
    chk1("post_rst_bvalid", BVALID, 1'b0);
    chk1("post_rst_awready", AWREADY, 1'b0);

    // Byte strobes
    axi_write(32'h08, 32'hAABB_CCDD, 4'b0010);
`ifdef LVDS_INPUT_WSTRB_EN
    chk("strb_dsize", dsize, 32'h0000_CC00);
    @(negedge ACLK);
    axi_write(32'h00, 32'h0000_0003, 4'b0000);
    chk1("strb0_cr_test", cr_test, 1'b0);
    chk1("strb0_cr_rt", cr_rt, 1'b0);
`else
    chk("strb_ignored_dsize", dsize, 32'hAABB_CCDC);
`endif
    @(negedge ACLK);
    chk1("final_bvalid", BVALID, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
